// File: rtl/alarm_controller.sv
// -----------------------------------------------------------------------------
// alarm_controller
//
// Alarm-clock controller. It compares a running time of day against either the
// user alarm time (IDLE) or an internally latched snooze time (SNOOZE) and
// drives a ringing indication with a blinking LED.
//
// Parameters
//   CLK_HZ      input clock frequency in Hz (one-second tick period)
//   RING_SEC    seconds of ringing before the alarm stops by itself
//   SNOOZE_MIN  snooze length in minutes (1..59)
//
// Ports
//   CLK100MHZ            in   sole clock, all state on the rising edge
//   reset                in   asynchronous active-low reset
//   seconds, minutes     in   running time, 0..59
//   hours                in   running time, 0..23
//   a_seconds, a_minutes in   alarm time, 0..59
//   a_hours              in   alarm time, 0..23
//   alarm_en             in   level, 1 arms the alarm; 0 forces IDLE
//   snooze_but, stop_but in   raw asynchronous button levels, active-high
//   alarm_LED            out  blinks at 2 Hz while ringing, 0 otherwise
//   ringing, snoozing    out  registered state flags
//   alarm_state          out  00 IDLE, 01 RINGING, 10 SNOOZE
// -----------------------------------------------------------------------------
module alarm_controller #(
    parameter int CLK_HZ     = 100000000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [4:0] hours,
    input  logic [5:0] a_seconds,
    input  logic [5:0] a_minutes,
    input  logic [4:0] a_hours,
    input  logic       alarm_en,
    input  logic       snooze_but,
    input  logic       stop_but,
    output logic       alarm_LED,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] alarm_state
);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RING   = 2'b01;
    localparam logic [1:0] ST_SNOOZE = 2'b10;

    // Counter geometry. The LED half period is a quarter second (2 Hz blink).
    localparam int LED_HALF = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
    localparam int TICK_W   = ($clog2(CLK_HZ) > 0) ? $clog2(CLK_HZ) : 1;
    localparam int LED_W    = ($clog2(LED_HALF) > 0) ? $clog2(LED_HALF) : 1;
    localparam int RING_W   = ($clog2(RING_SEC + 1) > 0) ? $clog2(RING_SEC + 1) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);
    localparam logic [LED_W-1:0]  LED_LAST  = LED_W'(LED_HALF - 1);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SEC - 1);

    // Button index within the synchronizer vectors.
    localparam int BTN_SNZ = 0;
    localparam int BTN_STP = 1;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [1:0]        btn_s1_q, btn_s2_q, btn_prev_q;
    logic [16:0]       prev_t_q;
    logic              prev_vld_q;
    logic              match_q, match_d;
    logic [16:0]       snooze_t_q, snooze_t_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
    logic [LED_W-1:0]  led_cnt_q, led_cnt_d;
    logic              led_q, led_d;
    logic              ringing_q, snoozing_q;

    // -------------------------------------------------------------------------
    // Button synchronizers and rising-edge detectors
    // -------------------------------------------------------------------------
    logic [1:0] btn_raw;
    logic [1:0] btn_act;
    logic       snz_act;
    logic       stp_act;

    assign btn_raw[BTN_SNZ] = snooze_but;
    assign btn_raw[BTN_STP] = stop_but;

    // btn_s2_q is the synchronized level; btn_prev_q holds it one cycle older,
    // so an action is exactly one cycle wide per press.
    assign btn_act = btn_s2_q & ~btn_prev_q;
    assign snz_act = btn_act[BTN_SNZ];
    assign stp_act = btn_act[BTN_STP];

    // -------------------------------------------------------------------------
    // Time compare
    // -------------------------------------------------------------------------
    logic [16:0] now_t;
    logic [16:0] alarm_t;
    logic [16:0] target_t;
    logic        time_moved;

    assign now_t    = {hours, minutes, seconds};
    assign alarm_t  = {a_hours, a_minutes, a_seconds};
    assign target_t = (state_q == ST_SNOOZE) ? snooze_t_q : alarm_t;

    // prev_vld_q keeps the first cycle after reset from looking like a time
    // change, so a held time equal to the alarm does not re-fire after reset.
    assign time_moved = prev_vld_q && (now_t != prev_t_q);

    // The match fires once per entry into the target second and is blocked
    // while the alarm is disarmed.
    assign match_d = alarm_en && time_moved && (now_t == target_t);

    // -------------------------------------------------------------------------
    // Snooze target: current time plus SNOOZE_MIN minutes, seconds unchanged.
    // -------------------------------------------------------------------------
    logic [6:0] snz_min_sum;
    logic [5:0] snz_min;
    logic [4:0] snz_hr;

    assign snz_min_sum = {1'b0, minutes} + 7'(SNOOZE_MIN);

    always_comb begin
        snz_min = snz_min_sum[5:0];
        snz_hr  = hours;
        if (snz_min_sum >= 7'd60) begin
            snz_min = 6'(snz_min_sum - 7'd60);
            snz_hr  = (hours >= 5'd23) ? 5'd0 : hours + 5'd1;
        end
    end

    // -------------------------------------------------------------------------
    // State machine
    // -------------------------------------------------------------------------
    logic tick;
    logic ring_done;

    assign tick      = (tick_cnt_q == TICK_LAST);
    assign ring_done = tick && (ring_cnt_q == RING_LAST);

    always_comb begin
        state_d    = state_q;
        snooze_t_d = snooze_t_q;
        if (!alarm_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Stop has no meaning here, so a coincident stop press
                    // cannot suppress the alarm.
                    if (match_q) begin
                        state_d = ST_RING;
                    end
                end
                ST_RING: begin
                    // Stop outranks snooze when both land in the same cycle.
                    if (stp_act) begin
                        state_d = ST_IDLE;
                    end else if (snz_act) begin
                        state_d    = ST_SNOOZE;
                        snooze_t_d = {snz_hr, snz_min, seconds};
                    end else if (ring_done) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SNOOZE: begin
                    if (stp_act) begin
                        state_d = ST_IDLE;
                    end else if (match_q) begin
                        state_d = ST_RING;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Ring timing: one-second tick, ring seconds, LED blink. All counters are
    // zero outside RINGING, so entry always starts a clean ringing period.
    // -------------------------------------------------------------------------
    always_comb begin
        tick_cnt_d = '0;
        ring_cnt_d = '0;
        led_cnt_d  = '0;
        led_d      = 1'b0;
        if (state_d == ST_RING) begin
            if (state_q != ST_RING) begin
                led_d = 1'b1;
            end else begin
                tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
                ring_cnt_d = tick ? ring_cnt_q + 1'b1 : ring_cnt_q;
                if (led_cnt_q == LED_LAST) begin
                    led_cnt_d = '0;
                    led_d     = ~led_q;
                end else begin
                    led_cnt_d = led_cnt_q + 1'b1;
                    led_d     = led_q;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            btn_prev_q <= '0;
            prev_t_q   <= '0;
            prev_vld_q <= 1'b0;
            match_q    <= 1'b0;
            snooze_t_q <= '0;
            tick_cnt_q <= '0;
            ring_cnt_q <= '0;
            led_cnt_q  <= '0;
            led_q      <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_s1_q   <= btn_raw;
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_s2_q;
            prev_t_q   <= now_t;
            prev_vld_q <= 1'b1;
            match_q    <= match_d;
            snooze_t_q <= snooze_t_d;
            tick_cnt_q <= tick_cnt_d;
            ring_cnt_q <= ring_cnt_d;
            led_cnt_q  <= led_cnt_d;
            led_q      <= led_d;
            ringing_q  <= (state_d == ST_RING);
            snoozing_q <= (state_d == ST_SNOOZE);
        end
    end

    assign alarm_state = state_q;
    assign ringing     = ringing_q;
    assign snoozing    = snoozing_q;
    assign alarm_LED   = led_q;

endmodule

// File: tb/tb_alarm_controller.sv
// -----------------------------------------------------------------------------
// tb_alarm_controller
//
// Self-checking bench for alarm_controller (CLK_HZ=8, RING_SEC=3,
// SNOOZE_MIN=5). A behavioural model tracks time in seconds-of-day and the
// state as a small integer; one compare process checks every cycle. Directed
// scenarios add literal expectations, then a randomized phase follows.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alarm_controller;

    localparam int CLK_HZ     = 8;
    localparam int RING_SEC   = 3;
    localparam int SNOOZE_MIN = 5;

    logic       clk;
    logic       reset;
    logic [5:0] seconds, minutes, a_seconds, a_minutes;
    logic [4:0] hours, a_hours;
    logic       alarm_en, snooze_but, stop_but;
    logic       alarm_LED, ringing, snoozing;
    logic [1:0] alarm_state;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    alarm_controller #(
        .CLK_HZ    (CLK_HZ),
        .RING_SEC  (RING_SEC),
        .SNOOZE_MIN(SNOOZE_MIN)
    ) dut (
        .CLK100MHZ  (clk),
        .reset      (reset),
        .seconds    (seconds),
        .minutes    (minutes),
        .hours      (hours),
        .a_seconds  (a_seconds),
        .a_minutes  (a_minutes),
        .a_hours    (a_hours),
        .alarm_en   (alarm_en),
        .snooze_but (snooze_but),
        .stop_but   (stop_but),
        .alarm_LED  (alarm_LED),
        .ringing    (ringing),
        .snoozing   (snoozing),
        .alarm_state(alarm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Behavioural model (0 idle, 1 ringing, 2 snooze)
    // -------------------------------------------------------------------------
    int       m_state;
    bit       m_pend;      // a qualifying match was seen at the last edge
    int       m_age;       // cycles spent in the current ringing period
    int       m_snz_t;     // snooze target, seconds of day
    bit       m_prev_ok;
    int       m_prev_t;
    logic [2:0] snz_h, stp_h; // button samples, [0] newest

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state   <= 0;
            m_pend    <= 0;
            m_age     <= 0;
            m_snz_t   <= 0;
            m_prev_ok <= 0;
            m_prev_t  <= 0;
            snz_h     <= '0;
            stp_h     <= '0;
        end else begin : mdl
            int  cur, alm, tgt, ns;
            bit  sa, pa;
            cur = int'(hours) * 3600 + int'(minutes) * 60 + int'(seconds);
            alm = int'(a_hours) * 3600 + int'(a_minutes) * 60 + int'(a_seconds);
            // A press becomes an action two edges after it is first sampled.
            sa  = snz_h[1] && !snz_h[2];
            pa  = stp_h[1] && !stp_h[2];
            ns  = m_state;
            if (!alarm_en) ns = 0;
            else if (m_state == 0) begin
                if (m_pend) ns = 1;
            end else if (m_state == 1) begin
                if (pa) ns = 0;
                else if (sa) begin
                    ns = 2;
                    m_snz_t <= (((cur / 60) + SNOOZE_MIN) % 1440) * 60 + (cur % 60);
                end else if (m_age == CLK_HZ * RING_SEC - 1) ns = 0;
            end else begin
                if (pa) ns = 0;
                else if (m_pend) ns = 1;
            end
            tgt = (m_state == 2) ? m_snz_t : alm;
            m_pend    <= alarm_en && m_prev_ok && (cur != m_prev_t) && (cur == tgt);
            m_prev_ok <= 1;
            m_prev_t  <= cur;
            if (ns == 1 && m_state != 1) m_age <= 0;
            else if (m_state == 1)       m_age <= m_age + 1;
            m_state <= ns;
            snz_h   <= {snz_h[1:0], snooze_but};
            stp_h   <= {stp_h[1:0], stop_but};
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin : cmp
            logic [1:0] e_st;
            logic       e_led, e_ring, e_snz;
            e_st   = 2'(m_state);
            e_ring = (m_state == 1);
            e_snz  = (m_state == 2);
            e_led  = (m_state == 1) && (((m_age / (CLK_HZ / 4)) % 2) == 0);
            checks++;
            if ({alarm_state, ringing, snoozing, alarm_LED} !== {e_st, e_ring, e_snz, e_led}) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t: got state=%0d ring=%0b snz=%0b led=%0b, required state=%0d ring=%0b snz=%0b led=%0b",
                         $time, alarm_state, ringing, snoozing, alarm_LED, e_st, e_ring, e_snz, e_led);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s t=%0t: got %0d, required %0d", nm, $time, act, exp_v);
        end else begin
            $display("ok   %s t=%0t: %0d", nm, $time, act);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hours   = 5'(h);
        minutes = 6'(m);
        seconds = 6'(s);
    endtask

    task automatic set_alarm(input int h, input int m, input int s);
        a_hours   = 5'(h);
        a_minutes = 6'(m);
        a_seconds = 6'(s);
    endtask

    // Bring time to one second before the alarm, step onto it, and wait the
    // two-cycle match latency.
    task automatic fire(input string nm, input int h, input int m, input int s);
        int t0;
        t0 = h * 3600 + m * 60 + s - 1;
        set_alarm(h, m, s);
        set_time(t0 / 3600, (t0 / 60) % 60, t0 % 60);
        cyc(2);
        set_time(h, m, s);
        cyc(2);
        chk(nm, int'(alarm_state), 1);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    logic [7:0] led_pat;
    int td;

    initial begin
        reset = 1'b0;
        alarm_en = 1'b0; snooze_but = 1'b0; stop_but = 1'b0;
        set_time(0, 0, 0);
        set_alarm(0, 0, 0);
        cyc(3);
        cmp_en = 1;
        chk("reset_outputs", int'({alarm_state, ringing, snoozing, alarm_LED}), 0);

        // Arm at 07:30:00, step time onto it.
        reset = 1'b1;
        alarm_en = 1'b1;
        set_alarm(7, 30, 0);
        set_time(7, 29, 59);
        cyc(4);
        set_time(7, 30, 0);
        cyc(1);
        chk("match_latency1", int'(alarm_state), 0);
        cyc(1);
        led_pat = 8'b00110011;
        for (int a = 0; a < 34; a++) begin
            chk($sformatf("ring_age%0d", a), int'(alarm_state), (a < 24) ? 1 : 0);
            if (a < 8) chk($sformatf("led_age%0d", a), int'(alarm_LED), int'(led_pat[a]));
            cyc(1);
        end

        // Snooze across midnight.
        fire("ring_2358", 23, 58, 10);
        snooze_but = 1'b1; cyc(1); snooze_but = 1'b0; cyc(1);
        chk("snz_latency", int'(alarm_state), 1);
        cyc(1);
        chk("snz_enter", int'(alarm_state), 2);
        chk("snz_flag", int'(snoozing), 1);
        chk("model_snz_time", m_snz_t, 190);
        cyc(5);
        chk("snz_hold", int'(alarm_state), 2);
        set_time(0, 3, 10);
        cyc(1);
        chk("snz_match_lat", int'(alarm_state), 2);
        cyc(1);
        chk("snz_refire", int'(alarm_state), 1);
        stop_but = 1'b1; cyc(1); stop_but = 1'b0; cyc(2);
        chk("stop_from_ring", int'(alarm_state), 0);

        // Simultaneous stop and snooze.
        fire("ring_0100", 1, 0, 0);
        stop_but = 1'b1; snooze_but = 1'b1; cyc(1);
        stop_but = 1'b0; snooze_but = 1'b0; cyc(1);
        chk("both_latency", int'(alarm_state), 1);
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            chk("both_state", int'(alarm_state), 0);
            chk("both_no_snz", int'(snoozing), 0);
        end

        // Disarm while snoozing.
        fire("ring_0200", 2, 0, 0);
        snooze_but = 1'b1; cyc(1); snooze_but = 1'b0; cyc(2);
        chk("snz_before_dis", int'(alarm_state), 2);
        alarm_en = 1'b0;
        cyc(1);
        chk("disarm", int'(alarm_state), 0);
        alarm_en = 1'b1;
        cyc(3);
        chk("no_refire_rearm", int'(alarm_state), 0);

        // Asynchronous reset mid-ringing, then no re-fire on a held time.
        fire("ring_0210", 2, 10, 0);
        cyc(3);
        #2 reset = 1'b0;
        #1 chk("async_reset", int'({alarm_state, ringing, snoozing, alarm_LED}), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            chk("no_refire_rst", int'(alarm_state), 0);
        end

        // Sub-cycle glitches on both buttons while ringing.
        fire("ring_0220", 2, 20, 0);
        #1 stop_but = 1'b1;
        #2 stop_but = 1'b0;
        @(negedge clk);
        #1 snooze_but = 1'b1;
        #2 snooze_but = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk("glitch", int'(alarm_state), 1);
        end

        // Randomized phase against the model.
        td = 2 * 3600 + 20 * 60;
        for (int i = 0; i < 4000; i++) begin
            int r;
            if ($urandom_range(0, 999) < 3) begin
                #2 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
            r = $urandom_range(0, 99);
            if (r < 25)      td = (td + 1) % 86400;
            else if (r < 28) td = (td + 300) % 86400;
            else if (r < 29) td = $urandom_range(0, 86399);
            if (m_state == 2 && $urandom_range(0, 99) < 10) td = m_snz_t;
            set_time(td / 3600, (td / 60) % 60, td % 60);
            if ($urandom_range(0, 99) < 3) begin
                int at;
                at = (td + $urandom_range(1, 6)) % 86400;
                set_alarm(at / 3600, (at / 60) % 60, at % 60);
            end
            if ($urandom_range(0, 99) < 8) snooze_but = ~snooze_but;
            if ($urandom_range(0, 99) < 3) stop_but = ~stop_but;
            if (alarm_en) begin
                if ($urandom_range(0, 199) == 0) alarm_en = 1'b0;
            end else if ($urandom_range(0, 99) < 20) alarm_en = 1'b1;
            cyc(1);
        end

        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 Parameter CLK_HZ, default 100000000, input clock frequency in Hz.
REQ-002 Parameter RING_SEC, default 60, seconds of ringing before auto-stop.
REQ-003 Parameter SNOOZE_MIN, default 5, snooze length in minutes (1..59).
REQ-004 CLK100MHZ  input  1  sole clock, all state rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 seconds, minutes  input  6 each  running time, 0..59.
REQ-007 hours  input  5  running time, 0..23.
REQ-008 a_seconds, a_minutes  input  6 each  alarm time, 0..59.
REQ-009 a_hours  input  5  alarm time, 0..23.
REQ-010 alarm_en  input  1  level; 1 arms the alarm.
REQ-011 snooze_but, stop_but  input  1 each  asynchronous raw button levels, active-high.
REQ-012 alarm_LED  output  1  blinks at 2 Hz while ringing.
REQ-013 ringing, snoozing  output  1 each  state flags.
REQ-014 alarm_state  output  2  00 IDLE, 01 RINGING, 10 SNOOZE.

Function
REQ-015 Buttons SHALL pass a 2-FF synchronizer; an action SHALL be the synchronized rising edge only, one cycle wide.
REQ-016 Match SHALL be registered: target time equals running time AND the running time differs from its value one cycle earlier (fires once per entry, 2-cycle latency from sec change to RINGING).
REQ-017 In IDLE the target SHALL be the alarm inputs; in SNOOZE the target SHALL be the internal snooze time.
REQ-018 IDLE -> RINGING on match with alarm_en=1.
REQ-019 RINGING -> IDLE on stop action, or after RING_SEC one-second ticks.
REQ-020 RINGING -> SNOOZE on snooze action; snooze time SHALL be latched as current time + SNOOZE_MIN minutes, seconds unchanged, minutes mod 60 with carry, hours mod 24.
REQ-021 SNOOZE -> RINGING on snooze-time match; SNOOZE -> IDLE on stop action.
REQ-022 Simultaneous stop and snooze actions SHALL resolve to stop.
REQ-023 alarm_en=0 SHALL force IDLE on the next edge from any state and block matches.
REQ-024 A match in IDLE coinciding with a stop action SHALL still enter RINGING (stop ignored in IDLE).
REQ-025 The one-second tick SHALL come from an internal counter of CLK_HZ cycles, restarted to 0 on entry to RINGING; the ring counter SHALL clear on entry to RINGING.
REQ-026 alarm_LED SHALL be 1 on entry to RINGING and toggle every CLK_HZ/4 cycles while RINGING; 0 in other states.
REQ-027 ringing = (state==RINGING), snoozing = (state==SNOOZE), registered.
REQ-028 Snooze latch at 23:58:xx with SNOOZE_MIN=5 SHALL give 00:03:xx.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, alarm_LED=0, ringing=0, snoozing=0, alarm_state=00, clear all counters, snooze time, previous-time and synchronizer registers.
REQ-030 Reset asserted mid-RINGING or mid-SNOOZE SHALL discard the snooze time; after release the alarm re-fires only on a fresh alarm match.
REQ-031 Release SHALL be synchronous to CLK100MHZ; first state change no earlier than the second edge after release.

Verification (CLK_HZ=8, RING_SEC=3, SNOOZE_MIN=5)
REQ-032 Alarm 07:30:00, alarm_en=1, time steps 07:29:59 -> 07:30:00 -> alarm_state=01 within 2 cycles, alarm_LED toggles every 2 cycles.
REQ-033 Ringing, no buttons -> IDLE after exactly 24 cycles from entry; time held at 07:30:00 SHALL not re-trigger.
REQ-034 Ringing at 23:58:10, snooze pulse -> state 10; time driven to 00:03:10 -> state 01.
REQ-035 Ringing, stop and snooze asserted same cycle -> state 00, snoozing never 1.
REQ-036 SNOOZE state, alarm_en dropped -> state 00 next edge; reset pulsed in RINGING -> all outputs 0 asynchronously.
REQ-037 Button glitch shorter than one clock between edges -> no state change.
